// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// fault codes, FSM states and the access-legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;

  typedef enum logic {S_IDLE, S_BUSY} lsu_state_t;

  // Illegal encodings win over misalignment; non-memory ops never fault.
  function automatic logic [1:0] access_fault(input logic       rd_en,
                                              input logic       wr_en,
                                              input logic [2:0] f3,
                                              input logic [1:0] addr_lo);
    logic illegal;
    logic misalign;
    illegal  = (rd_en & wr_en)
             | (rd_en & !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
             | (wr_en & !(f3 inside {F3_B, F3_H, F3_W}));
    misalign = ((f3[1:0] == 2'b01) && addr_lo[0])
             | ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
    if (!(rd_en | wr_en))
      return FAULT_NONE;
    else if (illegal)
      return FAULT_ILLEGAL;
    else if (misalign)
      return FAULT_MISALIGN;
    else
      return FAULT_NONE;
  endfunction

endpackage

// File: rtl/lsu_byte_ram.sv
// Word-organised data memory with per-byte write enables and a
// combinational read port sharing one address.
module lsu_byte_ram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [3:0]                     be,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i])
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: accepts one op from EX, performs the access after
// WAIT_STATES extra cycles and registers the result into the MEM/WB boundary.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0,
  parameter int RD_W        = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     alu_result,
  input  logic [31:0]     rs2_data,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      funct3,
  input  logic [RD_W-1:0] rd_in,
  input  logic            RegWrite_in,
  output logic            out_valid,
  output logic [31:0]     memData,
  output logic [31:0]     alu_result_out,
  output logic [RD_W-1:0] rd_out,
  output logic            RegWrite_out,
  output logic [1:0]      mem_fault
);

  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  lsu_state_t      state;
  logic [3:0]      cnt;

  logic [31:0]     h_addr;
  logic [31:0]     h_data;
  logic            h_rd_en;
  logic            h_wr_en;
  logic [2:0]      h_f3;
  logic [RD_W-1:0] h_rd;
  logic            h_rw;

  logic [31:0]     cur_addr;
  logic [31:0]     cur_data;
  logic            cur_rd_en;
  logic            cur_wr_en;
  logic [2:0]      cur_f3;
  logic [RD_W-1:0] cur_rd;
  logic            cur_rw;

  logic [1:0]      fault;
  logic            accept;
  logic            start_busy;
  logic            complete;
  logic [3:0]      be;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_ext;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid & in_ready;

  // While BUSY the op being completed is the held one; in IDLE it is the one
  // being accepted on this edge.
  always_comb begin
    cur_addr  = alu_result;
    cur_data  = rs2_data;
    cur_rd_en = MemRead;
    cur_wr_en = MemWrite;
    cur_f3    = funct3;
    cur_rd    = rd_in;
    cur_rw    = RegWrite_in;
    if (state == S_BUSY) begin
      cur_addr  = h_addr;
      cur_data  = h_data;
      cur_rd_en = h_rd_en;
      cur_wr_en = h_wr_en;
      cur_f3    = h_f3;
      cur_rd    = h_rd;
      cur_rw    = h_rw;
    end
  end

  assign fault      = access_fault(cur_rd_en, cur_wr_en, cur_f3, cur_addr[1:0]);
  assign start_busy = (WAIT_STATES != 0) && (state == S_IDLE) && accept
                    && (cur_rd_en | cur_wr_en) && (fault == FAULT_NONE);
  assign complete   = ((state == S_IDLE) && accept && !start_busy)
                    || ((state == S_BUSY) && (cnt == 4'd1));

  always_comb begin
    be    = 4'b0000;
    wdata = cur_data;
    case (cur_f3)
      F3_B: begin
        be    = 4'b0001 << cur_addr[1:0];
        wdata = {4{cur_data[7:0]}};
      end
      F3_H: begin
        be    = cur_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{cur_data[15:0]}};
      end
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    // Reset must never let a half-finished store reach memory.
    if (!(complete && cur_wr_en && (fault == FAULT_NONE) && !reset))
      be = 4'b0000;
  end

  lsu_byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .addr (cur_addr[2 +: AW]),
    .be   (be),
    .wdata(wdata),
    .rdata(rdata)
  );

  always_comb begin
    ld_byte = rdata[7:0];
    case (cur_addr[1:0])
      2'd0: ld_byte = rdata[7:0];
      2'd1: ld_byte = rdata[15:8];
      2'd2: ld_byte = rdata[23:16];
      2'd3: ld_byte = rdata[31:24];
      default: ld_byte = rdata[7:0];
    endcase
    ld_half = cur_addr[1] ? rdata[31:16] : rdata[15:0];
    case (cur_f3)
      F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
      F3_W:    ld_ext = rdata;
      F3_BU:   ld_ext = {24'd0, ld_byte};
      F3_HU:   ld_ext = {16'd0, ld_half};
      default: ld_ext = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= 4'd0;
      h_addr         <= 32'd0;
      h_data         <= 32'd0;
      h_rd_en        <= 1'b0;
      h_wr_en        <= 1'b0;
      h_f3           <= 3'd0;
      h_rd           <= '0;
      h_rw           <= 1'b0;
      out_valid      <= 1'b0;
      memData        <= 32'd0;
      alu_result_out <= 32'd0;
      rd_out         <= '0;
      RegWrite_out   <= 1'b0;
      mem_fault      <= FAULT_NONE;
    end else begin
      out_valid <= complete;
      if (accept) begin
        h_addr  <= alu_result;
        h_data  <= rs2_data;
        h_rd_en <= MemRead;
        h_wr_en <= MemWrite;
        h_f3    <= funct3;
        h_rd    <= rd_in;
        h_rw    <= RegWrite_in;
      end
      case (state)
        S_IDLE: begin
          if (start_busy) begin
            state <= S_BUSY;
            cnt   <= WS;
          end
        end
        S_BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (complete) begin
        memData        <= (cur_rd_en && (fault == FAULT_NONE)) ? ld_ext : 32'd0;
        alu_result_out <= cur_addr;
        rd_out         <= cur_rd;
        RegWrite_out   <= cur_rw && (fault == FAULT_NONE);
        mem_fault      <= fault;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: three instances (zero-wait, 3-wait and a
// small 2-wait memory used for the reset-abort case) share one clock.
module tb_mem_stage_lsu;
  import lsu_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rw;
  } stim_t;

  typedef struct {
    string       name;
    logic [31:0] md;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  flt;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  stim_t       drv [3];
  logic [2:0]  rst;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  rw_o;
  logic [31:0] md    [3];
  logic [31:0] alu_o [3];
  logic [4:0]  rd_o  [3];
  logic [1:0]  flt   [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  mem_stage_lsu #(.DEPTH_WORDS(16), .WAIT_STATES(0), .RD_W(5)) dut_a (
    .clk(clk), .reset(rst[0]), .in_valid(drv[0].valid), .in_ready(ir[0]),
    .alu_result(drv[0].addr), .rs2_data(drv[0].data), .MemRead(drv[0].rd_en),
    .MemWrite(drv[0].wr_en), .funct3(drv[0].f3), .rd_in(drv[0].rd),
    .RegWrite_in(drv[0].rw), .out_valid(ov[0]), .memData(md[0]),
    .alu_result_out(alu_o[0]), .rd_out(rd_o[0]), .RegWrite_out(rw_o[0]),
    .mem_fault(flt[0])
  );

  mem_stage_lsu #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .RD_W(5)) dut_b (
    .clk(clk), .reset(rst[1]), .in_valid(drv[1].valid), .in_ready(ir[1]),
    .alu_result(drv[1].addr), .rs2_data(drv[1].data), .MemRead(drv[1].rd_en),
    .MemWrite(drv[1].wr_en), .funct3(drv[1].f3), .rd_in(drv[1].rd),
    .RegWrite_in(drv[1].rw), .out_valid(ov[1]), .memData(md[1]),
    .alu_result_out(alu_o[1]), .rd_out(rd_o[1]), .RegWrite_out(rw_o[1]),
    .mem_fault(flt[1])
  );

  mem_stage_lsu #(.DEPTH_WORDS(16), .WAIT_STATES(2), .RD_W(5)) dut_c (
    .clk(clk), .reset(rst[2]), .in_valid(drv[2].valid), .in_ready(ir[2]),
    .alu_result(drv[2].addr), .rs2_data(drv[2].data), .MemRead(drv[2].rd_en),
    .MemWrite(drv[2].wr_en), .funct3(drv[2].f3), .rd_in(drv[2].rd),
    .RegWrite_in(drv[2].rw), .out_valid(ov[2]), .memData(md[2]),
    .alu_result_out(alu_o[2]), .rd_out(rd_o[2]), .RegWrite_out(rw_o[2]),
    .mem_fault(flt[2])
  );

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Drive one op, wait (bounded) for acceptance and queue its expected result.
  task automatic applyStimulus(input int k, input string name,
                               input logic rd_en, input logic wr_en, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [4:0] rd, input logic rw,
                               input logic [31:0] e_md, input logic e_rw, input logic [1:0] e_flt,
                               input int lat, input bit expect_out, output int acc);
    exp_t e;
    int   waited;
    drv[k].valid = 1'b1;
    drv[k].addr  = addr;
    drv[k].data  = data;
    drv[k].rd_en = rd_en;
    drv[k].wr_en = wr_en;
    drv[k].f3    = f3;
    drv[k].rd    = rd;
    drv[k].rw    = rw;
    waited = 0;
    while (!ir[k] && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!ir[k]) begin
      errors++;
      $display("[TB] FAIL %s accept_timeout: in_ready 0 after %0d cycles, expected 1", name, waited);
      acc = -1;
    end else begin
      acc = cyc + 1;
      if (expect_out) begin
        e.name = name;
        e.md   = e_md;
        e.alu  = addr;
        e.rd   = rd;
        e.rw   = e_rw;
        e.flt  = e_flt;
        e.due  = acc + lat;
        case (k)
          0: q0.push_back(e);
          1: q1.push_back(e);
          default: q2.push_back(e);
        endcase
      end
      @(negedge clk);
    end
    drv[k].valid = 1'b0;
  endtask

  task automatic checkOutput(input int k);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      errors++;
      $display("[TB] FAIL dut%0d unexpected_out_valid at cycle %0d: got out_valid 1, expected 0", k, cyc);
    end else begin
      if ({md[k], alu_o[k], rd_o[k], rw_o[k], flt[k]} !== {e.md, e.alu, e.rd, e.rw, e.flt}) begin
        errors++;
        $display("[TB] FAIL %s: got md=%08h alu=%08h rd=%0d rw=%0b flt=%02b, expected md=%08h alu=%08h rd=%0d rw=%0b flt=%02b",
                 e.name, md[k], alu_o[k], rd_o[k], rw_o[k], flt[k], e.md, e.alu, e.rd, e.rw, e.flt);
      end
      checks++;
      if (cyc != e.due) begin
        errors++;
        $display("[TB] FAIL %s latency: got out_valid at cycle %0d, expected %0d", e.name, cyc, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++)
      if (ov[k] === 1'b1) checkOutput(k);
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc0, acc1, acc2, acc3, pulses;
    rst = 3'b111;
    for (int k = 0; k < 3; k++) drv[k] = '0;
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      checkValue($sformatf("dut%0d_reset_state", k),
                 {md[k] | alu_o[k] | {27'd0, rd_o[k]} | {29'd0, rw_o[k], flt[k]}},
                 32'd0);
    checkValue("reset_ready", {29'd0, ir}, 32'd7);
    checkValue("reset_valid", {29'd0, ov}, 32'd0);
    rst = 3'b000;
    @(negedge clk);

    // Zero-wait-state instance: extension, byte enables, faults, wrap.
    applyStimulus(0, "a_sw10",    0, 1, F3_W,   32'h10, 32'h8000_00FF, 0, 0, 32'h0,         0, FAULT_NONE,     0, 1, acc0);
    applyStimulus(0, "a_lb10",    1, 0, F3_B,   32'h10, 32'h0,         5, 1, 32'hFFFF_FFFF, 1, FAULT_NONE,     0, 1, acc1);
    checkValue("a_back_to_back", 32'(acc1), 32'(acc0 + 1));
    applyStimulus(0, "a_lbu10",   1, 0, F3_BU,  32'h10, 32'h0,         5, 1, 32'h0000_00FF, 1, FAULT_NONE,     0, 1, acc0);
    applyStimulus(0, "a_lb13",    1, 0, F3_B,   32'h13, 32'h0,         6, 1, 32'hFFFF_FF80, 1, FAULT_NONE,     0, 1, acc0);
    applyStimulus(0, "a_sw20",    0, 1, F3_W,   32'h20, 32'h1122_3344, 0, 0, 32'h0,         0, FAULT_NONE,     0, 1, acc0);
    applyStimulus(0, "a_sh22",    0, 1, F3_H,   32'h22, 32'h1234_BEEF, 0, 0, 32'h0,         0, FAULT_NONE,     0, 1, acc0);
    applyStimulus(0, "a_lw20",    1, 0, F3_W,   32'h20, 32'h0,         5, 1, 32'hBEEF_3344, 1, FAULT_NONE,     0, 1, acc0);
    applyStimulus(0, "a_lh22",    1, 0, F3_H,   32'h22, 32'h0,         5, 1, 32'hFFFF_BEEF, 1, FAULT_NONE,     0, 1, acc0);
    applyStimulus(0, "a_lhu22",   1, 0, F3_HU,  32'h22, 32'h0,         5, 1, 32'h0000_BEEF, 1, FAULT_NONE,     0, 1, acc0);
    applyStimulus(0, "a_lh20",    1, 0, F3_H,   32'h20, 32'h0,         5, 1, 32'h0000_3344, 1, FAULT_NONE,     0, 1, acc0);
    applyStimulus(0, "a_sb21",    0, 1, F3_B,   32'h21, 32'hFFFF_FFA5, 0, 0, 32'h0,         0, FAULT_NONE,     0, 1, acc0);
    applyStimulus(0, "a_lw20b",   1, 0, F3_W,   32'h20, 32'h0,         5, 1, 32'hBEEF_A544, 1, FAULT_NONE,     0, 1, acc0);
    applyStimulus(0, "a_lw13mis", 1, 0, F3_W,   32'h13, 32'h0,         5, 1, 32'h0,         0, FAULT_MISALIGN, 0, 1, acc0);
    applyStimulus(0, "a_sw12mis", 0, 1, F3_W,   32'h12, 32'hDEAD_BEEF, 0, 0, 32'h0,         0, FAULT_MISALIGN, 0, 1, acc0);
    applyStimulus(0, "a_lw10",    1, 0, F3_W,   32'h10, 32'h0,         5, 1, 32'h8000_00FF, 1, FAULT_NONE,     0, 1, acc0);
    applyStimulus(0, "a_ld011",   1, 0, 3'b011, 32'h10, 32'h0,         5, 1, 32'h0,         0, FAULT_ILLEGAL,  0, 1, acc0);
    applyStimulus(0, "a_rdwr",    1, 1, F3_W,   32'h10, 32'h5555_5555, 5, 1, 32'h0,         0, FAULT_ILLEGAL,  0, 1, acc0);
    applyStimulus(0, "a_ld011mis",1, 0, 3'b011, 32'h13, 32'h0,         5, 1, 32'h0,         0, FAULT_ILLEGAL,  0, 1, acc0);
    applyStimulus(0, "a_st100",   0, 1, F3_BU,  32'h10, 32'h0000_0000, 0, 0, 32'h0,         0, FAULT_ILLEGAL,  0, 1, acc0);
    applyStimulus(0, "a_lw10b",   1, 0, F3_W,   32'h10, 32'h0,         5, 1, 32'h8000_00FF, 1, FAULT_NONE,     0, 1, acc0);
    applyStimulus(0, "a_lh21mis", 1, 0, F3_H,   32'h21, 32'h0,         5, 1, 32'h0,         0, FAULT_MISALIGN, 0, 1, acc0);
    applyStimulus(0, "a_alu",     0, 0, 3'b011, 32'h1234_5678, 32'h0,  7, 1, 32'h0,         1, FAULT_NONE,     0, 1, acc0);
    applyStimulus(0, "a_sw40",    0, 1, F3_W,   32'h40, 32'hCAFE_F00D, 0, 0, 32'h0,         0, FAULT_NONE,     0, 1, acc0);
    applyStimulus(0, "a_lw00",    1, 0, F3_W,   32'h00, 32'h0,         5, 1, 32'hCAFE_F00D, 1, FAULT_NONE,     0, 1, acc0);
    applyStimulus(0, "a_lw50",    1, 0, F3_W,   32'h50, 32'h0,         5, 1, 32'h8000_00FF, 1, FAULT_NONE,     0, 1, acc0);

    // Three wait states: stall window and a request held through it.
    applyStimulus(1, "b_sw00", 0, 1, F3_W, 32'h0, 32'h1357_9BDF, 0, 0, 32'h0, 0, FAULT_NONE, 3, 1, acc0);
    for (int i = 0; i < 3; i++) begin
      checkValue("b_ready_low", 32'(ir[1]), 32'd0);
      @(negedge clk);
    end
    checkValue("b_ready_high", 32'(ir[1]), 32'd1);
    applyStimulus(1, "b_lw00",  1, 0, F3_W,   32'h0,         32'h0, 5, 1, 32'h1357_9BDF, 1, FAULT_NONE,     3, 1, acc1);
    applyStimulus(1, "b_alu",   0, 0, 3'b011, 32'hA5A5_0000, 32'h0, 9, 1, 32'h0,         1, FAULT_NONE,     0, 1, acc2);
    checkValue("b_stall_accept", 32'(acc2), 32'(acc1 + 4));
    applyStimulus(1, "b_lw02",  1, 0, F3_W,   32'h2,         32'h0, 5, 1, 32'h0,         0, FAULT_MISALIGN, 0, 1, acc3);
    checkValue("b_fault_fast", 32'(acc3), 32'(acc2 + 1));
    repeat (6) @(negedge clk);

    // Reset while a store is in flight must discard it.
    applyStimulus(2, "c_sw04", 0, 1, F3_W, 32'h4, 32'h1111_1111, 0, 0, 32'h0, 0, FAULT_NONE, 2, 1, acc0);
    repeat (3) @(negedge clk);
    applyStimulus(2, "c_sw04_abort", 0, 1, F3_W, 32'h4, 32'h2222_2222, 0, 0, 32'h0, 0, FAULT_NONE, 2, 0, acc0);
    rst[2] = 1'b1;
    #1;
    checkValue("c_ready_in_reset", 32'(ir[2]), 32'd1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst[2] = 1'b0;
      if (ov[2]) pulses++;
    end
    checkValue("c_no_pulse", 32'(pulses), 32'd0);
    checkValue("c_alu_cleared", alu_o[2], 32'd0);
    checkValue("c_ready_after", 32'(ir[2]), 32'd1);
    applyStimulus(2, "c_lw04", 1, 0, F3_W, 32'h04, 32'h0, 5, 1, 32'h1111_1111, 1, FAULT_NONE, 2, 1, acc0);
    applyStimulus(2, "c_lw44", 1, 0, F3_W, 32'h44, 32'h0, 5, 1, 32'h1111_1111, 1, FAULT_NONE, 2, 1, acc1);
    repeat (8) @(negedge clk);

    checkValue("q0_drained", 32'(q0.size()), 32'd0);
    checkValue("q1_drained", 32'(q1.size()), 32'd0);
    checkValue("q2_drained", 32'(q2.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
